// File: rtl/accum_rr_scheduler_pkg.sv
// Shared definitions for the round-robin accumulator scheduler: FSM encoding and default widths.
package accum_rr_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_LIMIT = 2'd2
    } state_t;

    localparam int DEF_DATA_W = 4;
    localparam int DEF_ACC_W  = 32;
    // Grant index width is fixed at 3 bits so up to 8 requesters fit.
    localparam int IDX_W      = 3;

endpackage

// File: rtl/accum_rr_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: searches from ptr+1 upward, wraps, first set request wins.
module rr_arbiter
    import accum_rr_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx
);

    logic found;

    // Two passes: indices above ptr first, then the wrapped segment 0..ptr.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (en && !found && req[i] && (IDX_W'(i) > ptr)) begin
                grant[i] = 1'b1;
                idx      = IDX_W'(i);
                found    = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (en && !found && req[i] && (IDX_W'(i) <= ptr)) begin
                grant[i] = 1'b1;
                idx      = IDX_W'(i);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/accum_rr_scheduler.sv
// Shared accumulator sequencer: round-robin grant of per-requester increments into one count register,
// gated by enable, synchronous clear and a threshold stop released by limit_ack.
module accum_rr_scheduler
    import accum_rr_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ACC_W   = DEF_ACC_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      clear,
    input  logic [ACC_W-1:0]          threshold,
    input  logic                      limit_ack,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [ACC_W-1:0]          count,
    output logic                      limit_hit,
    output logic [2:0]                grant_id,
    output logic                      accepted
);

    function automatic logic [ACC_W-1:0] wrap_add(input logic [ACC_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        return a + {{(ACC_W-DATA_W){1'b0}}, b};
    endfunction

    state_t             state_q, state_nxt;
    logic [IDX_W-1:0]   ptr_q;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               arb_en;
    logic               hs;
    logic [DATA_W-1:0]  inc;
    logic [ACC_W-1:0]   count_nxt;
    logic               thr_hit;
    logic [ACC_W-1:0]   count_p1;
    logic [IDX_W-1:0]   grant_id_p1;
    logic               vld_p1;

    // Clear and a low enable both suppress the grant so no increment is lost or double-counted.
    assign arb_en = (state_q == ST_RUN) && enable && !clear;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_arb (
        .req  (req_valid),
        .ptr  (ptr_q),
        .en   (arb_en),
        .grant(grant),
        .idx  (grant_idx)
    );

    assign hs = |grant;

    always_comb begin
        inc = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                inc = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign count_nxt = clear ? '0 : (hs ? wrap_add(count_p1, inc) : count_p1);
    assign thr_hit   = (threshold != '0) && (count_nxt >= threshold);

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    state_nxt = ST_IDLE;
                end else if (thr_hit) begin
                    state_nxt = ST_LIMIT;
                end
            end
            ST_LIMIT: begin
                if (clear || limit_ack) begin
                    state_nxt = enable ? ST_RUN : ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Stage 1: count, grant bookkeeping and accepted pulse registered one edge after the handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q       <= IDX_W'(NUM_REQ - 1);
            count_p1    <= '0;
            grant_id_p1 <= '0;
            vld_p1      <= 1'b0;
        end else begin
            count_p1 <= count_nxt;
            vld_p1   <= hs;
            if (hs) begin
                ptr_q       <= grant_idx;
                grant_id_p1 <= grant_idx;
            end
        end
    end

    assign req_ready = grant;
    assign count     = count_p1;
    assign limit_hit = (state_q == ST_LIMIT);
    assign grant_id  = grant_id_p1;
    assign accepted  = vld_p1;

endmodule

// File: tb/tb_accum_rr_scheduler.sv
// Bench for accum_rr_scheduler: directed vector table, hand-written corner sequences and
// randomized traffic compared against a cycle-level behavioural model.
module tb_accum_rr_scheduler;

    localparam int N  = 4;
    localparam int DW = 4;
    localparam int AW = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            enable;
    logic            clear;
    logic [AW-1:0]   threshold;
    logic            limit_ack;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic [AW-1:0]   count;
    logic            limit_hit;
    logic [2:0]      grant_id;
    logic            accepted;

    int n_vec  = 0;
    int n_fail = 0;

    accum_rr_scheduler #(
        .NUM_REQ(N),
        .DATA_W (DW),
        .ACC_W  (AW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .clear    (clear),
        .threshold(threshold),
        .limit_ack(limit_ack),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_ready(req_ready),
        .count    (count),
        .limit_hit(limit_hit),
        .grant_id (grant_id),
        .accepted (accepted)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model (0=idle, 1=run, 2=limit) ----------------
    int            m_state;
    logic [AW-1:0] m_count;
    int            m_ptr;
    int            m_gid;
    bit            m_acc;

    task automatic model_reset();
        m_state = 0;
        m_count = '0;
        m_ptr   = N - 1;
        m_gid   = 0;
        m_acc   = 1'b0;
    endtask

    function automatic logic [N-1:0] model_ready(input logic en, input logic cl, input logic [N-1:0] v);
        logic [N-1:0] r;
        r = '0;
        if (m_state == 1 && en && !cl) begin
            for (int k = 1; k <= N; k++) begin
                int i;
                i = (m_ptr + k) % N;
                if (v[i] && r == '0) r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic model_edge(input logic en, input logic cl, input logic ack, input logic [AW-1:0] thr,
                              input logic [N*DW-1:0] d, input logic [N-1:0] rdy);
        int            g;
        logic [DW-1:0] dd;
        logic [AW-1:0] nc;
        int            ns;
        g = -1;
        for (int i = 0; i < N; i++) if (rdy[i]) g = i;
        dd = '0;
        if (g >= 0) dd = DW'(d >> (g * DW));
        if (cl)          nc = '0;
        else if (g >= 0) nc = m_count + {{(AW-DW){1'b0}}, dd};
        else             nc = m_count;
        ns = m_state;
        case (m_state)
            0: if (en) ns = 1;
            1: begin
                if (!en) ns = 0;
                else if (thr != 0 && nc >= thr) ns = 2;
            end
            default: if (cl || ack) ns = en ? 1 : 0;
        endcase
        m_acc = (g >= 0);
        if (g >= 0) begin
            m_ptr = g;
            m_gid = g;
        end
        m_count = nc;
        m_state = ns;
    endtask

    // ---------------- cycle driver ----------------
    logic [N-1:0] s_ready;
    logic [N-1:0] m_rdy;

    task automatic cycle(input logic en, input logic cl, input logic ack, input logic [AW-1:0] thr,
                         input logic [N-1:0] v, input logic [N*DW-1:0] d);
        enable    = en;
        clear     = cl;
        limit_ack = ack;
        threshold = thr;
        req_valid = v;
        req_data  = d;
        m_rdy     = model_ready(en, cl, v);
        #3;
        s_ready = req_ready;
        @(posedge clk);
        #1;
        model_edge(en, cl, ack, thr, d, m_rdy);
    endtask

    task automatic check_model(input string tag);
        chk32({tag, ".ready"},    32'(s_ready),    32'(m_rdy));
        chk32({tag, ".count"},    count,           m_count);
        chk32({tag, ".limit"},    32'(limit_hit),  (m_state == 2) ? 32'd1 : 32'd0);
        chk32({tag, ".grant_id"}, 32'(grant_id),   32'(m_gid));
        chk32({tag, ".accepted"}, 32'(accepted),   32'(m_acc));
    endtask

    task automatic mcycle(input string tag, input logic en, input logic cl, input logic ack,
                          input logic [AW-1:0] thr, input logic [N-1:0] v, input logic [N*DW-1:0] d);
        cycle(en, cl, ack, thr, v, d);
        check_model(tag);
    endtask

    task automatic do_reset(input bit chk_now);
        reset = 1'b1;
        #1;
        if (chk_now) begin
            chk32("async_reset.count",    count,           32'd0);
            chk32("async_reset.limit",    32'(limit_hit),  32'd0);
            chk32("async_reset.accepted", 32'(accepted),   32'd0);
            chk32("async_reset.grant_id", 32'(grant_id),   32'd0);
        end
        enable    = 1'b0;
        clear     = 1'b0;
        limit_ack = 1'b0;
        threshold = '0;
        req_valid = '0;
        req_data  = '0;
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit            rst_before;
        logic          en;
        logic          cl;
        logic          ack;
        logic [AW-1:0] thr;
        logic [N-1:0]  v;
        logic [15:0]   d;
        logic [N-1:0]  e_ready;
        logic [AW-1:0] e_count;
        logic          e_lim;
        logic [2:0]    e_gid;
        logic          e_acc;
    } tvec_t;

    tvec_t tv[13];

    logic [AW-1:0] rthr;

    initial begin
        tv[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 4'b0001, 16'h0005, 4'b0000, 32'd0,  1'b0, 3'd0, 1'b0};
        tv[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 4'b0001, 16'h0005, 4'b0001, 32'd5,  1'b0, 3'd0, 1'b1};
        tv[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 4'b0001, 16'h0005, 4'b0001, 32'd10, 1'b0, 3'd0, 1'b1};
        tv[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 4'b0001, 16'h0005, 4'b0001, 32'd15, 1'b0, 3'd0, 1'b1};
        tv[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 4'b1111, 16'h4321, 4'b0000, 32'd0,  1'b0, 3'd0, 1'b0};
        tv[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 4'b1111, 16'h4321, 4'b0001, 32'd1,  1'b0, 3'd0, 1'b1};
        tv[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 4'b1111, 16'h4321, 4'b0010, 32'd3,  1'b0, 3'd1, 1'b1};
        tv[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 4'b1111, 16'h4321, 4'b0100, 32'd6,  1'b0, 3'd2, 1'b1};
        tv[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 4'b1111, 16'h4321, 4'b1000, 32'd10, 1'b0, 3'd3, 1'b1};
        tv[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 4'b1111, 16'h4321, 4'b0001, 32'd11, 1'b0, 3'd0, 1'b1};
        tv[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 4'b1111, 16'h4321, 4'b0010, 32'd13, 1'b0, 3'd1, 1'b1};
        tv[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 4'b1111, 16'h4321, 4'b0100, 32'd16, 1'b0, 3'd2, 1'b1};
        tv[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 4'b1111, 16'h4321, 4'b1000, 32'd20, 1'b0, 3'd3, 1'b1};

        reset     = 1'b1;
        enable    = 1'b0;
        clear     = 1'b0;
        limit_ack = 1'b0;
        threshold = '0;
        req_valid = '0;
        req_data  = '0;
        @(posedge clk);
        #1;
        chk32("reset.count",    count,           32'd0);
        chk32("reset.limit",    32'(limit_hit),  32'd0);
        chk32("reset.grant_id", 32'(grant_id),   32'd0);
        chk32("reset.accepted", 32'(accepted),   32'd0);
        chk32("reset.ready",    32'(req_ready),  32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        model_reset();

        for (int i = 0; i < 13; i++) begin
            if (tv[i].rst_before) do_reset(1'b0);
            cycle(tv[i].en, tv[i].cl, tv[i].ack, tv[i].thr, tv[i].v, tv[i].d);
            chk32($sformatf("tv%0d.ready", i),    32'(s_ready),   32'(tv[i].e_ready));
            chk32($sformatf("tv%0d.count", i),    count,          tv[i].e_count);
            chk32($sformatf("tv%0d.limit", i),    32'(limit_hit), 32'(tv[i].e_lim));
            chk32($sformatf("tv%0d.grant_id", i), 32'(grant_id),  32'(tv[i].e_gid));
            chk32($sformatf("tv%0d.accepted", i), 32'(accepted),  32'(tv[i].e_acc));
        end

        // Wraparound: 0xFFFFFFFE + 3 from requester 1 wraps to 1 and stays below threshold 0x10.
        do_reset(1'b0);
        mcycle("wrap.idle", 1'b1, 1'b0, 1'b0, 32'h0, 4'b0000, 16'h0000);
        force dut.count_p1 = 32'hFFFF_FFFE;
        #1;
        release dut.count_p1;
        m_count = 32'hFFFF_FFFE;
        mcycle("wrap.add", 1'b1, 1'b0, 1'b0, 32'h10, 4'b0010, 16'h0030);
        chk32("wrap.count_const", count,          32'h0000_0001);
        chk32("wrap.limit_const", 32'(limit_hit), 32'd0);

        // Threshold stop, held request, ack back to RUN.
        do_reset(1'b0);
        mcycle("thr.idle", 1'b1, 1'b0, 1'b0, 32'd10, 4'b0100, 16'h0600);
        mcycle("thr.add1", 1'b1, 1'b0, 1'b0, 32'd10, 4'b0100, 16'h0600);
        mcycle("thr.add2", 1'b1, 1'b0, 1'b0, 32'd10, 4'b0100, 16'h0600);
        chk32("thr.count_const", count,          32'd12);
        chk32("thr.limit_const", 32'(limit_hit), 32'd1);
        mcycle("thr.held", 1'b1, 1'b0, 1'b0, 32'd10, 4'b0100, 16'h0600);
        chk32("thr.ready_held", 32'(s_ready), 32'd0);
        mcycle("thr.ack", 1'b1, 1'b0, 1'b1, 32'd10, 4'b0100, 16'h0600);
        chk32("thr.limit_after_ack", 32'(limit_hit), 32'd0);
        mcycle("thr.resume", 1'b1, 1'b0, 1'b0, 32'd10, 4'b0100, 16'h0600);
        chk32("thr.resume_count", count, 32'd18);

        // Clear against a pending request, then clear out of LIMIT with enable low.
        do_reset(1'b0);
        mcycle("clr.idle",  1'b1, 1'b0, 1'b0, 32'd0, 4'b0001, 16'h0007);
        mcycle("clr.add",   1'b1, 1'b0, 1'b0, 32'd0, 4'b0001, 16'h0007);
        mcycle("clr.clear", 1'b1, 1'b1, 1'b0, 32'd0, 4'b0001, 16'h0007);
        chk32("clr.ready_in_clear", 32'(s_ready), 32'd0);
        chk32("clr.count_zero",     count,        32'd0);
        mcycle("clr.after", 1'b1, 1'b0, 1'b0, 32'd0, 4'b0001, 16'h0007);
        chk32("clr.count_seven", count, 32'd7);
        mcycle("clr.tolimit", 1'b1, 1'b0, 1'b0, 32'd5, 4'b0000, 16'h0007);
        chk32("clr.limit_set", 32'(limit_hit), 32'd1);
        mcycle("clr.inlimit", 1'b0, 1'b1, 1'b0, 32'd5, 4'b0000, 16'h0007);
        chk32("clr.limit_clear", 32'(limit_hit), 32'd0);
        chk32("clr.count_clear", count,          32'd0);
        mcycle("clr.idle2", 1'b0, 1'b0, 1'b0, 32'd5, 4'b0001, 16'h0007);

        // Asynchronous reset with count at 0x23, then requester 0 first after release.
        do_reset(1'b0);
        mcycle("ar.idle", 1'b1, 1'b0, 1'b0, 32'd0, 4'b0001, 16'h000F);
        mcycle("ar.a1",   1'b1, 1'b0, 1'b0, 32'd0, 4'b0001, 16'h000F);
        mcycle("ar.a2",   1'b1, 1'b0, 1'b0, 32'd0, 4'b0001, 16'h000F);
        mcycle("ar.a3",   1'b1, 1'b0, 1'b0, 32'd0, 4'b0001, 16'h0005);
        chk32("ar.count_23", count, 32'h23);
        enable    = 1'b1;
        req_valid = 4'b0001;
        do_reset(1'b1);
        mcycle("ar.idle2", 1'b1, 1'b0, 1'b0, 32'd0, 4'b1111, 16'h1111);
        mcycle("ar.first", 1'b1, 1'b0, 1'b0, 32'd0, 4'b1111, 16'h1111);
        chk32("ar.first_ready", 32'(s_ready), 32'd1);

        // Randomized traffic against the model.
        rthr = '0;
        for (int c = 0; c < 800; c++) begin
            logic en, cl, ack;
            if ($urandom_range(99) == 0) do_reset(1'b1);
            if ($urandom_range(31) == 0)
                rthr = ($urandom_range(1) == 0) ? 32'd0 : m_count + 32'($urandom_range(60));
            en  = ($urandom_range(7) != 0);
            cl  = ($urandom_range(15) == 0);
            ack = ($urandom_range(7) == 0);
            mcycle("rnd", en, cl, ack, rthr, 4'($urandom), 16'($urandom));
            chk32("rnd.onehot", 32'($onehot0(s_ready)), 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/accum_rr_scheduler.md
Name: accum_rr_scheduler

Overview:
Shares one 32-bit accumulator (adder plus count register) among NUM_REQ requesters. Each requester offers a 4-bit increment. A round-robin arbiter grants at most one requester per cycle, and the granted value is added into the count. A small FSM gates accumulation with an enable, a synchronous clear, and a threshold stop that holds until software acknowledges it. The block sits between the producer agents and the shared accumulator datapath, and is its only sequencer.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 4, increment width per requester
ACC_W, 32, accumulator width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
enable  in  1  level; 1 = accumulation permitted
clear  in  1  synchronous pulse; zeroes count
threshold  in  ACC_W  stop level; 0 = threshold disabled
limit_ack  in  1  pulse; releases the LIMIT state
req_valid  in  NUM_REQ  per-requester request
req_data  in  NUM_REQ*DATA_W  increments; requester i uses bits [i*DATA_W +: DATA_W]
req_ready  out  NUM_REQ  one-hot grant (combinational)
count  out  ACC_W  accumulator value (registered)
limit_hit  out  1  high while in LIMIT
grant_id  out  3  index of the last accepted requester (registered)
accepted  out  1  1-cycle pulse, registered, one cycle after a handshake

Behaviour:
- Reset values: state=IDLE, count=0, limit_hit=0, grant_id=0, accepted=0, rr pointer=NUM_REQ-1 (so requester 0 has first priority).
- States: IDLE, RUN, LIMIT (2-bit encoding).
- IDLE -> RUN when enable=1.
- RUN -> IDLE when enable=0. No transaction is granted in the cycle enable is sampled low.
- RUN -> LIMIT when threshold!=0 and next count >= threshold (unsigned compare on the post-add value).
- LIMIT -> RUN on limit_ack if enable=1, otherwise LIMIT -> IDLE.
- LIMIT -> IDLE on clear when enable=0.
- Grant:
  - Only in RUN with clear=0.
  - Search req_valid starting at (ptr+1) mod NUM_REQ and wrap; first set bit wins.
  - req_ready is one-hot, or all 0 if no valid request.
  - Handshake = req_valid[i] & req_ready[i]. Data must be held stable while valid=1 and ready=0.
- On a handshake:
  - count <= count + zero-extended req_data[i] at the next edge (latency 1).
  - ptr <= i, grant_id <= i, accepted <= 1.
  - Requester i drops to lowest priority next cycle.
- Arithmetic: modulo 2^ACC_W, no saturation. 0xFFFFFFFF + 2 = 0x00000001. A threshold crossing is evaluated on the wrapped value.
- clear:
  - Has priority over accumulation. req_ready is forced to 0 in the clear cycle, so no increment is lost or double-counted.
  - count <= 0 at the next edge.
  - In LIMIT, clear also exits LIMIT (to RUN if enable=1, else IDLE).
  - The rr pointer is not affected by clear.
- LIMIT: req_ready=0, count frozen, limit_hit=1.
- limit_ack outside LIMIT is ignored.
- Threshold change while in LIMIT does not exit LIMIT.
- Reset mid-transaction: immediate return to the reset values above. In-flight grants are discarded and requesters must re-present.
- Zero increments (req_data=0) are legal and consume a grant.

Decomposition:
- Shared package/include: state encodings (ST_IDLE=0, ST_RUN=1, ST_LIMIT=2), default DATA_W/ACC_W constants.
- Sub-module rr_arbiter:
  - Parameter NUM_REQ.
  - Inputs: req, ptr, en. Output: one-hot grant plus encoded index.
  - Purely combinational.
- The top level holds the FSM, pointer, count register and adder.

Test Plan:
- Reset, enable=1, req_valid=0001, req_data[0]=5 for 3 cycles -> count 5,10,15; grant_id=0; accepted pulses each cycle.
- All 4 valid, data 1/2/3/4, 8 cycles -> grant order 0,1,2,3,0,1,2,3; count=20; req_ready strictly one-hot.
- count preloaded to 0xFFFFFFFE via accumulation, requester 1 adds 3 -> count=0x00000001, no flag.
- threshold=10, requester 2 adds 6 twice -> count=12, limit_hit=1, req_ready=0 while valid held. limit_ack -> RUN the next cycle, accumulation resumes.
- clear asserted in the same cycle as req_valid=0001 with data=7 -> req_ready=0, count=0 next edge, then 7 the following edge. clear in LIMIT with enable=0 -> IDLE, limit_hit=0.
- reset asserted asynchronously mid-stream (count=0x23) -> count=0, limit_hit=0 immediately. After release, requester 0 gets first priority.
